// File: rtl/ctrl_sequencer_if.sv
// Datapath-facing bundle of the sequencer: instruction fetch port,
// ALU flags in, register addresses / ALU code / strobes out.
interface ctrl_sequencer_if #(
    parameter int PC_W = 8
);
    logic [PC_W-1:0] imem_addr;
    logic [31:0]     imem_data;
    logic [2:0]      flags;
    logic [4:0]      r1;
    logic [4:0]      r2;
    logic [4:0]      ALUc;
    logic            regw;
    logic            memw;
    logic            memr;

    modport master (
        output imem_addr,
        input  imem_data,
        input  flags,
        output r1,
        output r2,
        output ALUc,
        output regw,
        output memw,
        output memr
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        output flags,
        input  r1,
        input  r2,
        input  ALUc,
        input  regw,
        input  memw,
        input  memr
    );
endinterface

// File: rtl/ctrl_sequencer.sv
// Multi-cycle Moore sequencer: fetches and decodes instructions and
// drives register addresses, ALU code and strobes of the datapath.
module ctrl_sequencer #(
    parameter int PC_W = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    ctrl_sequencer_if.master dp,
    output logic           busy,
    output logic           halted,
    output logic           illegal
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [5:0] OP_ALU   = 6'b000000;
    localparam logic [5:0] OP_LOAD  = 6'b100011;
    localparam logic [5:0] OP_STORE = 6'b101011;
    localparam logic [5:0] OP_BRZ   = 6'b000100;
    localparam logic [5:0] OP_HALT  = 6'b111111;
    localparam logic [PC_W-1:0] PC_ONE = 1;

    state_t          state, state_nx;
    logic [PC_W-1:0] pc, pc_nx;
    logic [31:0]     ir, ir_nx;
    logic [4:0]      r1_q, r1_nx;
    logic [4:0]      r2_q, r2_nx;
    logic [4:0]      aluc_q, aluc_nx;
    logic            ill_q, ill_nx;

    logic [5:0]  opcode;
    logic        is_alu, is_load, is_store, is_brz, is_halt;
    logic [31:0] imm_ext;
    logic        unused_flags;

    assign opcode   = ir[31:26];
    assign is_alu   = (opcode == OP_ALU);
    assign is_load  = (opcode == OP_LOAD);
    assign is_store = (opcode == OP_STORE);
    assign is_brz   = (opcode == OP_BRZ);
    assign is_halt  = (opcode == OP_HALT);
    assign imm_ext  = {{16{ir[15]}}, ir[15:0]};
    assign unused_flags = ^dp.flags[2:1];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= S_IDLE;
            pc     <= '0;
            ir     <= '0;
            r1_q   <= '0;
            r2_q   <= '0;
            aluc_q <= '0;
            ill_q  <= 1'b0;
        end else begin
            state  <= state_nx;
            pc     <= pc_nx;
            ir     <= ir_nx;
            r1_q   <= r1_nx;
            r2_q   <= r2_nx;
            aluc_q <= aluc_nx;
            ill_q  <= ill_nx;
        end
    end

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        ir_nx    = ir;
        r1_nx    = r1_q;
        r2_nx    = r2_q;
        aluc_nx  = aluc_q;
        ill_nx   = ill_q;
        unique case (state)
            S_IDLE: begin
                if (start)
                    state_nx = S_FETCH;
            end
            S_FETCH: begin
                ir_nx    = dp.imem_data;
                pc_nx    = pc + PC_ONE;
                state_nx = S_DECODE;
            end
            S_DECODE: begin
                r1_nx   = ir[25:21];
                r2_nx   = ir[20:16];
                // memory ops use the ALU to add the base address
                aluc_nx = (is_load || is_store) ? 5'd0 : ir[4:0];
                if (is_alu || is_load || is_store || is_brz)
                    state_nx = S_EXEC;
                else if (is_halt)
                    state_nx = S_HALT;
                else begin
                    ill_nx   = 1'b1;
                    state_nx = S_FETCH;
                end
            end
            S_EXEC: begin
                if (is_alu)
                    state_nx = S_WB;
                else if (is_load || is_store)
                    state_nx = S_MEM;
                else
                    state_nx = S_FETCH;
                // pc already points past the branch
                if (is_brz && dp.flags[0])
                    pc_nx = pc + imm_ext[PC_W-1:0];
            end
            S_MEM: begin
                state_nx = is_load ? S_WB : S_FETCH;
            end
            S_WB: begin
                state_nx = S_FETCH;
            end
            S_HALT: begin
                state_nx = S_HALT;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    assign dp.imem_addr = pc;
    assign dp.r1        = r1_q;
    assign dp.r2        = r2_q;
    assign dp.ALUc      = aluc_q;
    assign dp.regw      = (state == S_WB);
    assign dp.memw      = (state == S_MEM) && is_store;
    assign dp.memr      = ((state == S_MEM) || (state == S_WB)) && is_load;
    assign busy         = (state != S_IDLE) && (state != S_HALT);
    assign halted       = (state == S_HALT);
    assign illegal      = ill_q;
endmodule
